vga_scanout: RTL and testbench

- Display-side reader of video memory. Generates 640x480@60 VGA timing from the 50 MHz system clock and drives the pixel outputs.
- Requests 32-pixel groups from mem_map over the vga_en / vga_x_group / vga_y_val interface and consumes the returned vga_bgr_buf.
- Double-buffered: while one group is displayed, the next is prefetched. Counterpart to the CPU write path at 0xF80C that fills video memory.

---
 rtl/vga_scanout.sv | 170 +++++++++++++++++
 tb/tb_vga_scanout.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_scanout.sv
// rtl/vga_scanout.sv - VGA timing generator with double-buffered 32-pixel group prefetch
module vga_scanout #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic              clk,
   input  logic              rst,
   output logic              vga_en,
   output logic [4:0]        vga_x_group,
   output logic [8:0]        vga_y_val,
   input  logic [31:0][11:0] vga_bgr_buf,
   input  logic              vga_buf_valid,
   output logic [3:0]        vga_r,
   output logic [3:0]        vga_g,
   output logic [3:0]        vga_b,
   output logic              vga_hs,
   output logic              vga_vs,
   output logic              underrun
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [10:0] H_VIS      = 11'(H_VISIBLE);
   localparam logic [10:0] H_MAX      = 11'(H_TOTAL - 1);
   localparam logic [10:0] HS_LO      = 11'(H_VISIBLE + H_FRONT);
   localparam logic [10:0] HS_HI      = 11'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0]  V_VIS      = 10'(V_VISIBLE);
   localparam logic [9:0]  V_MAX      = 10'(V_TOTAL - 1);
   localparam logic [9:0]  VS_LO      = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0]  VS_HI      = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [4:0]  LAST_GROUP = 5'(H_VISIBLE / 32 - 1);

   typedef enum logic [1:0] {IDLE, REQ, FULL} fetch_state_t;

   fetch_state_t      state;
   fetch_state_t      state_nxt;
   logic              pix_en;
   logic [10:0]       h_cnt;
   logic [9:0]        v_cnt;
   logic [9:0]        next_line;
   logic [4:0]        grp;
   logic              visible;
   logic              swap;
   logic              trig_line;
   logic              trig_group;
   logic              stale;
   logic              load_req;
   logic              capture;
   logic [4:0]        req_group;
   logic [8:0]        req_line;
   logic [31:0][11:0] shadow_buf;
   logic [31:0][11:0] disp_buf;
   logic [31:0][11:0] cur_buf;
   logic [11:0]       pix;

   assign grp        = h_cnt[9:5];
   assign visible    = (h_cnt < H_VIS) && (v_cnt < V_VIS);
   assign swap       = pix_en && visible && (h_cnt[4:0] == 5'd0);
   assign next_line  = (v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1;
   assign trig_line  = pix_en && (h_cnt == H_VIS) && (next_line < V_VIS);
   assign trig_group = swap && (grp != LAST_GROUP);
   assign vga_en     = (state == REQ);

   // The group entering display at a swap is visible on its own first pixel.
   assign cur_buf = swap ? ((state == FULL) ? shadow_buf : '0) : disp_buf;
   assign pix     = cur_buf[h_cnt[4:0]];

   always_comb begin
      state_nxt = state;
      load_req  = 1'b0;
      capture   = 1'b0;
      req_group = grp + 5'd1;
      req_line  = v_cnt[8:0];
      case (state)
         IDLE: begin
            if (trig_group) begin
               load_req  = 1'b1;
               state_nxt = REQ;
            end else if (trig_line) begin
               load_req  = 1'b1;
               req_group = 5'd0;
               req_line  = next_line[8:0];
               state_nxt = REQ;
            end
         end
         REQ: begin
            // A response whose group has already been swapped is useless.
            if (vga_buf_valid) begin
               if (stale || swap) begin
                  state_nxt = IDLE;
               end else begin
                  capture   = 1'b1;
                  state_nxt = FULL;
               end
            end
         end
         FULL: begin
            if (swap) begin
               if (trig_group) begin
                  load_req  = 1'b1;
                  state_nxt = REQ;
               end else begin
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pix_en      <= 1'b0;
         h_cnt       <= '0;
         v_cnt       <= '0;
         state       <= IDLE;
         stale       <= 1'b0;
         vga_x_group <= '0;
         vga_y_val   <= '0;
         shadow_buf  <= '0;
         disp_buf    <= '0;
         vga_r       <= '0;
         vga_g       <= '0;
         vga_b       <= '0;
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         underrun    <= 1'b0;
      end else begin
         pix_en <= ~pix_en;
         state  <= state_nxt;
         if (pix_en) begin
            if (h_cnt == H_MAX) begin
               h_cnt <= '0;
               v_cnt <= (v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1;
            end else begin
               h_cnt <= h_cnt + 11'd1;
            end
            vga_r  <= visible ? pix[3:0]  : 4'd0;
            vga_g  <= visible ? pix[7:4]  : 4'd0;
            vga_b  <= visible ? pix[11:8] : 4'd0;
            vga_hs <= !((h_cnt >= HS_LO) && (h_cnt <= HS_HI));
            vga_vs <= !((v_cnt >= VS_LO) && (v_cnt <= VS_HI));
         end
         if (load_req) begin
            vga_x_group <= req_group;
            vga_y_val   <= req_line;
            stale       <= 1'b0;
         end else if ((state == REQ) && swap) begin
            stale <= 1'b1;
         end
         if (capture) begin
            shadow_buf <= vga_bgr_buf;
         end
         if (swap) begin
            disp_buf <= cur_buf;
            if (state != FULL) begin
               underrun <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_vga_scanout.sv
// tb/tb_vga_scanout.sv - randomized check of vga_scanout against a position-based display model
module tb_vga_scanout;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst;
   logic [1:0]        en_o, hs_o, vs_o, ur_o, valid_i;
   logic [4:0]        xg_o [2];
   logic [8:0]        y_o [2];
   logic [3:0]        r_o [2], g_o [2], b_o [2];
   logic [31:0][11:0] bgr_i [2];

   vga_scanout u0 (
      .clk(clk), .rst(rst), .vga_en(en_o[0]), .vga_x_group(xg_o[0]), .vga_y_val(y_o[0]),
      .vga_bgr_buf(bgr_i[0]), .vga_buf_valid(valid_i[0]), .vga_r(r_o[0]), .vga_g(g_o[0]),
      .vga_b(b_o[0]), .vga_hs(hs_o[0]), .vga_vs(vs_o[0]), .underrun(ur_o[0])
   );

   vga_scanout #(
      .H_VISIBLE(128), .H_FRONT(8), .H_SYNC(16), .H_BACK(8),
      .V_VISIBLE(8), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
   ) u1 (
      .clk(clk), .rst(rst), .vga_en(en_o[1]), .vga_x_group(xg_o[1]), .vga_y_val(y_o[1]),
      .vga_bgr_buf(bgr_i[1]), .vga_buf_valid(valid_i[1]), .vga_r(r_o[1]), .vga_g(g_o[1]),
      .vga_b(b_o[1]), .vga_hs(hs_o[1]), .vga_vs(vs_o[1]), .underrun(ur_o[1])
   );

   int p_hv  [2] = '{640, 128};
   int p_ht  [2] = '{800, 160};
   int p_vv  [2] = '{480, 8};
   int p_vt  [2] = '{525, 15};
   int p_hsa [2] = '{656, 136};
   int p_hse [2] = '{751, 151};
   int p_vsa [2] = '{490, 10};
   int p_vse [2] = '{491, 11};

   int          m_e [2], last_e [2], m_ry [2], m_rg [2];
   bit          m_req [2], m_stale [2], m_have [2];
   logic [11:0] m_sh [2][32];
   logic [11:0] m_disp [2][32];
   logic [11:0] x_rgb [2];
   bit          x_hs [2], x_vs [2], x_ur [2];

   bit r_busy [2];
   int r_cnt [2], r_y [2];

   int checks, errors, rst2_cnt;
   bit first_run;

   task automatic chk(input string nm, input int k, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s inst%0d edge=%0d got %0h want %0h", nm, k, last_e[k], act, exp);
      end
   endtask

   task automatic model_step(input int k);
      int p, h, v, g, nl;
      bit pe, vis, swap, trig_a, pre_req, pre_have;
      logic [11:0] inc [32];
      if (!rst) begin
         m_e[k] = 0; m_req[k] = 0; m_stale[k] = 0; m_have[k] = 0;
         m_ry[k] = 0; m_rg[k] = 0;
         x_rgb[k] = 0; x_hs[k] = 1; x_vs[k] = 1; x_ur[k] = 0;
         for (int i = 0; i < 32; i++) begin
            m_disp[k][i] = 0;
            m_sh[k][i] = 0;
         end
         return;
      end
      last_e[k] = m_e[k];
      pe = (m_e[k] % 2) == 1;
      p = m_e[k] / 2;
      h = p % p_ht[k];
      v = (p / p_ht[k]) % p_vt[k];
      g = h / 32;
      nl = (v + 1) % p_vt[k];
      vis = pe && h < p_hv[k] && v < p_vv[k];
      swap = vis && (h % 32) == 0;
      trig_a = pe && h == p_hv[k] && nl < p_vv[k];
      pre_req = m_req[k];
      pre_have = m_have[k];
      for (int i = 0; i < 32; i++) inc[i] = pre_have ? m_sh[k][i] : 12'h0;
      if (pe) begin
         x_rgb[k] = !vis ? 12'h0 : (swap ? inc[h % 32] : m_disp[k][h % 32]);
         x_hs[k] = !(h >= p_hsa[k] && h <= p_hse[k]);
         x_vs[k] = !(v >= p_vsa[k] && v <= p_vse[k]);
      end
      if (valid_i[k] && pre_req) begin
         m_req[k] = 0;
         if (!(m_stale[k] || swap)) begin
            m_have[k] = 1;
            for (int i = 0; i < 32; i++) m_sh[k][i] = bgr_i[k][i];
         end
      end
      if (swap) begin
         for (int i = 0; i < 32; i++) m_disp[k][i] = inc[i];
         if (!pre_have) x_ur[k] = 1;
         m_have[k] = 0;
         if (pre_req) begin
            m_stale[k] = 1;
         end else if (g < p_hv[k] / 32 - 1) begin
            m_req[k] = 1; m_stale[k] = 0; m_ry[k] = v; m_rg[k] = g + 1;
         end
      end
      if (trig_a && !pre_req && !pre_have) begin
         m_req[k] = 1; m_stale[k] = 0; m_ry[k] = nl; m_rg[k] = 0;
      end
      m_e[k]++;
   endtask

   task automatic compare(input int k);
      chk("vga_en", k, en_o[k], m_req[k]);
      if (m_req[k] || !rst) begin
         chk("x_group", k, xg_o[k], m_rg[k]);
         chk("y_val", k, y_o[k], m_ry[k]);
      end
      chk("rgb", k, {b_o[k], g_o[k], r_o[k]}, x_rgb[k]);
      chk("hs", k, hs_o[k], x_hs[k]);
      chk("vs", k, vs_o[k], x_vs[k]);
      chk("underrun", k, ur_o[k], x_ur[k]);
   endtask

   // Hand-derived edge numbers for the first frame after the initial reset.
   task automatic literal_checks();
      case (last_e[0])
         0:    chk("lit_ur_start", 0, ur_o[0], 0);
         1:    chk("lit_ur_line0", 0, ur_o[0], 1);
         1279: chk("lit_en_idle", 0, en_o[0], 0);
         1281: begin
            chk("lit_en_prefetch", 0, en_o[0], 1);
            chk("lit_prefetch_x", 0, xg_o[0], 0);
            chk("lit_prefetch_y", 0, y_o[0], 1);
         end
         1312: chk("lit_hs_pre", 0, hs_o[0], 1);
         1313: chk("lit_hs_fall", 0, hs_o[0], 0);
         1504: chk("lit_hs_low_end", 0, hs_o[0], 0);
         1505: chk("lit_hs_rise", 0, hs_o[0], 1);
         2912: chk("lit_hs_pre2", 0, hs_o[0], 1);
         2913: chk("lit_hs_fall2", 0, hs_o[0], 0);
         1667: chk("lit_px33_line1", 0, {b_o[0], g_o[0], r_o[0]}, 12'h111);
         3541: chk("lit_px170_black", 0, {b_o[0], g_o[0], r_o[0]}, 0);
         3601: chk("lit_px200_black", 0, {b_o[0], g_o[0], r_o[0]}, 0);
         3659: chk("lit_px229_line2", 0, {b_o[0], g_o[0], r_o[0]}, 12'h555);
         default: ;
      endcase
      case (last_e[1])
         3200: chk("lit_vs_pre", 1, vs_o[1], 1);
         3201: chk("lit_vs_fall", 1, vs_o[1], 0);
         3840: chk("lit_vs_low_end", 1, vs_o[1], 0);
         3841: chk("lit_vs_rise", 1, vs_o[1], 1);
         8001: chk("lit_vs_fall2", 1, vs_o[1], 0);
         4735: chk("lit_blank_idle", 1, en_o[1], 0);
         4737: begin
            chk("lit_line0_prefetch", 1, en_o[1], 1);
            chk("lit_line0_x", 1, xg_o[1], 0);
            chk("lit_line0_y", 1, y_o[1], 0);
         end
         default: ;
      endcase
   endtask

   function automatic int pick_delay(input int k, input int y, input int g);
      if (k == 0 && y == 2 && g == 5) return 100;
      if (k == 0 && y == 3 && g == 2) return 40;
      if (k == 0 && y < 5) return 10;
      return $urandom_range(2, 70);
   endfunction

   task automatic responder(input int k);
      valid_i[k] = 1'b0;
      if (r_busy[k]) begin
         r_cnt[k]--;
         if (r_cnt[k] == 0) begin
            valid_i[k] = 1'b1;
            r_busy[k] = 0;
            for (int i = 0; i < 32; i++)
               bgr_i[k][i] = (k == 0 && r_y[k] < 5) ? {3{4'(i)}} : 12'($urandom);
         end
      end else if (rst && en_o[k]) begin
         r_busy[k] = 1;
         r_y[k] = y_o[k];
         r_cnt[k] = pick_delay(k, int'(y_o[k]), int'(xg_o[k])) - 1;
      end else if (k == 1 && $urandom_range(0, 63) == 0) begin
         valid_i[k] = 1'b1;
         for (int i = 0; i < 32; i++) bgr_i[k][i] = 12'($urandom);
      end
   endtask

   initial begin
      rst = 1'b0;
      valid_i = '0;
      bgr_i[0] = '0;
      bgr_i[1] = '0;
      checks = 0;
      errors = 0;
      rst2_cnt = 0;
      first_run = 1;
      for (int k = 0; k < 2; k++) begin
         r_busy[k] = 0; r_cnt[k] = 0; r_y[k] = 0; last_e[k] = 0;
      end
      for (int cyc = 0; cyc < 50000; cyc++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin
            model_step(k);
            compare(k);
         end
         if (first_run && rst) literal_checks();
         for (int k = 0; k < 2; k++) responder(k);
         if (cyc == 2) rst = 1'b1;
         if (rst2_cnt > 0) begin
            rst2_cnt--;
            if (rst2_cnt == 0) rst = 1'b1;
         end else if (first_run && cyc >= 38000 && (en_o[1] || cyc >= 39000)) begin
            rst = 1'b0;
            rst2_cnt = 3;
            first_run = 0;
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
